// File: rtl/hex_display_mux.sv
// Multiplexed 7-segment driver: scans NUM_DIGITS latched hex nibbles with per-digit
// blanking, blinking and a lamp test, and registers seg/dig_sel with optional inversion.
module hex_display_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 12500000,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digit_value,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    lamp_test,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_sel
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int BLK_W = $clog2(BLINK_DIV);
    localparam logic [6:0]            SEG_POL = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_POL = {NUM_DIGITS{ACTIVE_LOW}};

    logic [4*NUM_DIGITS-1:0] val_q, val_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic [NUM_DIGITS-1:0]   blink_q, blink_d;
    logic [REF_W-1:0]        ref_cnt_q, ref_cnt_d;
    logic [BLK_W-1:0]        blk_cnt_q, blk_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;

    logic                    ref_wrap;
    logic                    blk_wrap;
    logic [4*NUM_DIGITS-1:0] val_sh;
    logic [NUM_DIGITS-1:0]   en_sh;
    logic [NUM_DIGITS-1:0]   blink_sh;
    logic [6:0]              seg_raw;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'b1111110;
            4'h1: seg_decode = 7'b0110000;
            4'h2: seg_decode = 7'b1101101;
            4'h3: seg_decode = 7'b1111001;
            4'h4: seg_decode = 7'b0110011;
            4'h5: seg_decode = 7'b1011011;
            4'h6: seg_decode = 7'b1011111;
            4'h7: seg_decode = 7'b1110000;
            4'h8: seg_decode = 7'b1111111;
            4'h9: seg_decode = 7'b1111011;
            4'hA: seg_decode = 7'b1110111;
            4'hB: seg_decode = 7'b0011111;
            4'hC: seg_decode = 7'b1001110;
            4'hD: seg_decode = 7'b0111101;
            4'hE: seg_decode = 7'b1001111;
            default: seg_decode = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        val_d   = val_q;
        en_d    = en_q;
        blink_d = blink_q;
        if (load) begin
            val_d   = digit_value;
            en_d    = digit_en;
            blink_d = blink_en;
        end

        ref_wrap  = (ref_cnt_q == REF_W'(REFRESH_DIV - 1));
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (ref_wrap) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        blk_wrap      = (blk_cnt_q == BLK_W'(BLINK_DIV - 1));
        blk_cnt_d     = blk_wrap ? '0 : blk_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q ^ blk_wrap;

        // Shift the selected digit down to bit 0 so any NUM_DIGITS indexes cleanly.
        val_sh   = val_q >> {idx_q, 2'b00};
        en_sh    = en_q >> idx_q;
        blink_sh = blink_q >> idx_q;

        if (lamp_test) begin
            seg_raw = 7'b1111111;
        end else if (!en_sh[0]) begin
            seg_raw = 7'b0000000;
        end else if (blink_sh[0] && blink_phase_q) begin
            seg_raw = 7'b0000000;
        end else begin
            seg_raw = seg_decode(val_sh[3:0]);
        end

        seg_d     = seg_raw ^ SEG_POL;
        dig_sel_d = (NUM_DIGITS'(1) << idx_q) ^ DIG_POL;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            val_q         <= '0;
            en_q          <= '0;
            blink_q       <= '0;
            ref_cnt_q     <= '0;
            blk_cnt_q     <= '0;
            blink_phase_q <= 1'b0;
            idx_q         <= '0;
            seg_q         <= SEG_POL;
            dig_sel_q     <= DIG_POL;
        end else begin
            val_q         <= val_d;
            en_q          <= en_d;
            blink_q       <= blink_d;
            ref_cnt_q     <= ref_cnt_d;
            blk_cnt_q     <= blk_cnt_d;
            blink_phase_q <= blink_phase_d;
            idx_q         <= idx_d;
            seg_q         <= seg_d;
            dig_sel_q     <= dig_sel_d;
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;
endmodule

// File: tb/tb_hex_display_mux.sv
// Bench for hex_display_mux: a 4-digit active-high instance and a 1-digit active-low
// instance, both compared every cycle against an arithmetic model of the scan.
module tb_hex_display_mux;
    localparam int N1 = 4, REF1 = 4, BLK1 = 8;
    localparam int REF2 = 3, BLK2 = 5;

    logic        clk = 1'b0;
    logic        resetn;
    logic        lamp_test;
    logic        load1;
    logic [15:0] value1;
    logic [3:0]  en1, blink1;
    logic [6:0]  seg1;
    logic [3:0]  dig1;
    logic        load2;
    logic [3:0]  value2;
    logic        en2, blink2;
    logic [6:0]  seg2;
    logic        dig2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hex_display_mux #(.NUM_DIGITS(N1), .REFRESH_DIV(REF1), .BLINK_DIV(BLK1), .ACTIVE_LOW(1'b0)) u_dut4 (
        .clk(clk), .resetn(resetn), .load(load1), .digit_value(value1), .digit_en(en1),
        .blink_en(blink1), .lamp_test(lamp_test), .seg(seg1), .dig_sel(dig1));

    hex_display_mux #(.NUM_DIGITS(1), .REFRESH_DIV(REF2), .BLINK_DIV(BLK2), .ACTIVE_LOW(1'b1)) u_dut1 (
        .clk(clk), .resetn(resetn), .load(load2), .digit_value(value2), .digit_en(en2),
        .blink_en(blink2), .lamp_test(lamp_test), .seg(seg2), .dig_sel(dig2));

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp_v);
        end
    endtask

    // Segment patterns straight from the decode table.
    function automatic logic [6:0] hex_pattern(input int v);
        case (v)
            0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;  3: return 7'b1111001;
            4: return 7'b0110011;  5: return 7'b1011011;  6: return 7'b1011111;  7: return 7'b1110000;
            8: return 7'b1111111;  9: return 7'b1111011; 10: return 7'b1110111; 11: return 7'b0011111;
            12: return 7'b1001110; 13: return 7'b0111101; 14: return 7'b1001111; default: return 7'b1000111;
        endcase
    endfunction

    function automatic logic [6:0] expect_seg(input int nib, input bit en, input bit blk,
                                              input bit phase, input bit lamp);
        if (lamp) return 7'b1111111;
        if (!en) return 7'b0000000;
        if (blk && phase) return 7'b0000000;
        return hex_pattern(nib);
    endfunction

    // Model: k counts non-reset edges since reset; digit and blink phase follow by division.
    int          k1, k2;
    logic [15:0] m_val1;
    logic [3:0]  m_en1, m_blk1;
    logic [3:0]  m_val2;
    bit          m_en2, m_blk2;
    logic [6:0]  exp_seg1, exp_seg2;
    logic [3:0]  exp_dig1;
    logic        exp_dig2;
    bit          primed = 0;

    always @(posedge clk) begin
        int idx, ph;
        if (!resetn) begin
            k1 = 0; k2 = 0;
            m_val1 = '0; m_en1 = '0; m_blk1 = '0;
            m_val2 = '0; m_en2 = 0; m_blk2 = 0;
            exp_seg1 = 7'b0000000; exp_dig1 = 4'b0000;
            exp_seg2 = 7'b1111111; exp_dig2 = 1'b1;
            primed = 1;
        end else begin
            idx = (k1 / REF1) % N1;
            ph  = (k1 / BLK1) % 2;
            exp_seg1 = expect_seg(int'(m_val1[4*idx +: 4]), m_en1[idx], m_blk1[idx], ph[0], lamp_test);
            exp_dig1 = 4'(1 << idx);
            if (load1) begin m_val1 = value1; m_en1 = en1; m_blk1 = blink1; end
            k1++;
            ph = (k2 / BLK2) % 2;
            exp_seg2 = ~expect_seg(int'(m_val2), m_en2, m_blk2, ph[0], lamp_test);
            exp_dig2 = 1'b0;
            if (load2) begin m_val2 = value2; m_en2 = en2; m_blk2 = blink2; end
            k2++;
        end
    end

    always @(negedge clk) begin
        if (primed) begin
            check_eq("seg4", {9'd0, seg1}, {9'd0, exp_seg1});
            check_eq("dig4", {12'd0, dig1}, {12'd0, exp_dig1});
            check_eq("seg1_al", {9'd0, seg2}, {9'd0, exp_seg2});
            check_eq("dig1_al", {15'd0, dig2}, {15'd0, exp_dig2});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load4(input logic [15:0] v, input logic [3:0] e, input logic [3:0] b);
        @(negedge clk);
        load1 = 1'b1; value1 = v; en1 = e; blink1 = b;
        @(negedge clk);
        load1 = 1'b0; value1 = $urandom; en1 = $urandom; blink1 = $urandom;
    endtask

    initial begin
        bit found;
        resetn = 1'b0; lamp_test = 1'b0;
        load1 = 1'b1; value1 = 16'hFFFF; en1 = 4'hF; blink1 = 4'h0;
        load2 = 1'b1; value2 = 4'h8; en2 = 1'b1; blink2 = 1'b0;
        cycles(3);
        load1 = 1'b0;
        resetn = 1'b1;
        load2 = 1'b1;
        cycles(1);
        load2 = 1'b0;

        // Counting digits 0..3 with a clean scan and wrap.
        load4(16'h3210, 4'b1111, 4'b0000);
        cycles(24);

        // Every nibble on digit 0, each held across a full scan.
        for (int v = 0; v < 16; v++) begin
            load4(16'(v), 4'b0001, 4'b0000);
            cycles(REF1 * N1);
        end

        // Blanked digit 1, blinking digit 0.
        load4(16'h9A5C, 4'b1101, 4'b0001);
        cycles(48);

        // Lamp test overrides blanking on every digit.
        load4(16'h0000, 4'b0000, 4'b0000);
        lamp_test = 1'b1;
        cycles(20);
        lamp_test = 1'b0;
        cycles(6);

        // Reset during digit 2, then scan with everything blank.
        load4(16'h4321, 4'b1111, 4'b0000);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (dig1 == 4'b0100) found = 1;
        end
        check_eq("wait_digit2", {15'd0, found}, 16'd1);
        resetn = 1'b0;
        cycles(1);
        resetn = 1'b1;
        cycles(20);

        // Randomized traffic including loads on refresh wraps and sporadic resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            load1  = ($urandom % 4) == 0;
            value1 = $urandom; en1 = $urandom; blink1 = $urandom;
            load2  = ($urandom % 5) == 0;
            value2 = $urandom; en2 = $urandom; blink2 = $urandom;
            lamp_test = ($urandom % 16) == 0;
            resetn = ($urandom % 250) != 0;
        end
        @(negedge clk);
        resetn = 1'b1; load1 = 1'b0; load2 = 1'b0; lamp_test = 1'b0;
        cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
